// File: rtl/vec_serializer_pkg.sv
// Shared types and helpers for the vector serializer.
// Holds the two-state FSM encoding and the lane-index width function.
package vec_serializer_pkg;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    // Lane index width; a single-lane vector still gets a 1-bit index.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vector_serializer_lane_counter.sv
// Lane index counter for the vector serializer.
// Ports: clk, reset (async, active-high), clr (to 0, has priority),
// inc (+1), cnt (current lane), term (cnt is the last lane).
module lane_counter
    import vec_serializer_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = lane_w(LANES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [LANE_W-1:0] cnt,
    output logic              term
);

    localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);

    logic [LANE_W-1:0] cnt_q;
    logic [LANE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == LAST);

endmodule

// File: rtl/vector_serializer.sv
// Drains a LANES*DATA_W vector one lane per beat onto a valid/ready stream.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data vector
// input; out_valid/out_ready/out_data/out_lane lane output; busy while a
// vector is held; out_last only with VEC_SERIALIZER_LAST_EN defined.
module vector_serializer
    import vec_serializer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_W-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [lane_w(LANES)-1:0]    out_lane,
    output logic                        busy
`ifdef VEC_SERIALIZER_LAST_EN
    ,
    output logic                        out_last
`endif
);

    localparam int LANE_W = lane_w(LANES);

    ser_state_t state_q;
    ser_state_t state_d;

    logic [LANES*DATA_W-1:0] shadow_q;
    logic [LANES*DATA_W-1:0] shadow_d;

    logic [LANE_W-1:0] lane;
    logic              lane_term;
    logic              lane_clr;
    logic              lane_inc;
    logic              capture;
    logic [DATA_W-1:0] lane_data;

    lane_counter #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (lane_clr),
        .inc   (lane_inc),
        .cnt   (lane),
        .term  (lane_term)
    );

    // In SEND a new vector is only taken on the final beat's handshake,
    // so the next vector follows without a bubble.
    assign in_ready = (state_q == SER_IDLE) || (lane_term && out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        lane_clr = 1'b0;
        lane_inc = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (capture) begin
                    shadow_d = in_data;
                    lane_clr = 1'b1;
                    state_d  = SER_SEND;
                end
            end
            SER_SEND: begin
                if (capture) begin
                    shadow_d = in_data;
                    lane_clr = 1'b1;
                end else if (out_ready && lane_term) begin
                    lane_clr = 1'b1;
                    state_d  = SER_IDLE;
                end else if (out_ready) begin
                    lane_inc = 1'b1;
                end
            end
            default: begin
                state_d  = SER_IDLE;
                lane_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SER_IDLE;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_W'(i)) begin
                lane_data = shadow_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign out_valid = (state_q == SER_SEND);
    assign busy      = out_valid;
    // Idle output is held at zero rather than leaking stale shadow data.
    assign out_data  = out_valid ? lane_data : '0;
    assign out_lane  = lane;

`ifdef VEC_SERIALIZER_LAST_EN
    assign out_last  = out_valid && lane_term;
`endif

endmodule

// File: tb/tb_vector_serializer.sv
// Directed self-checking bench for vector_serializer (DATA_W=16, LANES=4).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_vector_serializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        busy;
`ifdef VEC_SERIALIZER_LAST_EN
    logic        out_last;
`endif

    int vectors;
    int miscompares;

    localparam logic [63:0] V1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] V2 = 64'hDDDD_CCCC_BBBB_AAAA;

    vector_serializer #(
        .DATA_W (16),
        .LANES  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .busy      (busy)
`ifdef VEC_SERIALIZER_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one beat with out_ready=1, then advance through its edge.
    task automatic beat(input string tag, input logic [15:0] d,
                        input logic [1:0] l);
        #1;
        chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, ".data"}, 64'(out_data), 64'(d));
        chk({tag, ".lane"}, 64'(out_lane), 64'(l));
        chk({tag, ".busy"}, 64'(busy), 64'(1'b1));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(l == 2'd3));
`ifdef VEC_SERIALIZER_LAST_EN
        chk({tag, ".last"}, 64'(out_last), 64'(l == 2'd3));
`endif
        tick();
    endtask

    task automatic idle_chk(input string tag);
        #1;
        chk({tag, ".valid"}, 64'(out_valid), 64'(1'b0));
        chk({tag, ".busy"}, 64'(busy), 64'(1'b0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(1'b1));
        chk({tag, ".lane"}, 64'(out_lane), 64'(2'd0));
        chk({tag, ".data"}, 64'(out_data), 64'(16'h0));
`ifdef VEC_SERIALIZER_LAST_EN
        chk({tag, ".last"}, 64'(out_last), 64'(1'b0));
`endif
    endtask

    // Present a vector for one cycle in IDLE; it is captured on the edge.
    task automatic load(input logic [63:0] v, input logic keep_valid);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = keep_valid;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        idle_chk("reset");

        // Single vector at full rate.
        out_ready = 1'b1;
        load(V1, 1'b0);
        beat("s0", 16'h1111, 2'd0);
        beat("s1", 16'h2222, 2'd1);
        beat("s2", 16'h3333, 2'd2);
        beat("s3", 16'h4444, 2'd3);
        idle_chk("single_done");

        // Backpressure on lane 1 for three cycles.
        load(V1, 1'b0);
        beat("b0", 16'h1111, 2'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.valid", 64'(out_valid), 64'(1'b1));
            chk("stall.data", 64'(out_data), 64'(16'h2222));
            chk("stall.lane", 64'(out_lane), 64'(2'd1));
            chk("stall.in_ready", 64'(in_ready), 64'(1'b0));
            tick();
        end
        out_ready = 1'b1;
        beat("b1", 16'h2222, 2'd1);
        beat("b2", 16'h3333, 2'd2);
        beat("b3", 16'h4444, 2'd3);
        idle_chk("stall_done");

        // Back-to-back: second vector waits with in_valid held high.
        load(V1, 1'b1);
        in_data = V2;
        beat("bb0", 16'h1111, 2'd0);
        beat("bb1", 16'h2222, 2'd1);
        beat("bb2", 16'h3333, 2'd2);
        beat("bb3", 16'h4444, 2'd3);
        in_valid = 1'b0;
        beat("bb4", 16'hAAAA, 2'd0);
        beat("bb5", 16'hBBBB, 2'd1);
        beat("bb6", 16'hCCCC, 2'd2);
        beat("bb7", 16'hDDDD, 2'd3);
        idle_chk("b2b_done");

        // Reset mid-vector drops output at once.
        load(V1, 1'b0);
        beat("r0", 16'h1111, 2'd0);
        beat("r1", 16'h2222, 2'd1);
        reset = 1'b1;
        idle_chk("mid_reset");
        tick();
        reset = 1'b0;
        idle_chk("after_reset");
        load(V2, 1'b0);
        beat("r2", 16'hAAAA, 2'd0);
        beat("r3", 16'hBBBB, 2'd1);
        beat("r4", 16'hCCCC, 2'd2);
        beat("r5", 16'hDDDD, 2'd3);
        idle_chk("reset_done");

        // New data offered on lane 1 is ignored until the final beat.
        load(V1, 1'b0);
        beat("i0", 16'h1111, 2'd0);
        in_valid = 1'b1;
        in_data  = V2;
        beat("i1", 16'h2222, 2'd1);
        beat("i2", 16'h3333, 2'd2);
        beat("i3", 16'h4444, 2'd3);
        in_valid = 1'b0;
        beat("i4", 16'hAAAA, 2'd0);
        beat("i5", 16'hBBBB, 2'd1);
        beat("i6", 16'hCCCC, 2'd2);
        beat("i7", 16'hDDDD, 2'd3);
        idle_chk("ignore_done");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vector_serializer.md
# vector_serializer

Drains a captured multi-lane vector one lane per beat onto a narrow valid/ready stream. It is the read-side counterpart of the vector write path: upstream logic presents a full `LANES*DATA_W` vector, and a scalar consumer such as a memory write port or debug tap receives it lane by lane. It sits between the vector register file output and any single-lane sink in the ASIP datapath.

## Interface
- `DATA_W`, default 16: width of one lane in bits.
- `LANES`, default 4: number of lanes per vector. Must be at least 1.
- `LANE_W`, derived: `LANES > 1 ? $clog2(LANES) : 1`. Not user-overridable.

- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  upstream vector valid.
- `in_ready`  output  1  block can accept a vector this cycle.
- `in_data`  input  `LANES*DATA_W`  vector. Lane i is `in_data[i*DATA_W +: DATA_W]`; lane 0 is in the LSBs.
- `out_valid`  output  1  a lane beat is presented.
- `out_ready`  input  1  downstream accepts the beat.
- `out_data`  output  `DATA_W`  current lane value.
- `out_lane`  output  `LANE_W`  index of the current lane.
- `busy`  output  1  a vector is held and not fully drained.
- `out_last`  output  1  current beat is lane `LANES-1`. Present only with `VEC_SERIALIZER_LAST_EN`.

## Operation
- State machine with two states:
  - `IDLE`: `in_ready` is 1 and `out_valid` is 0.
  - `SEND`: `out_valid` is 1.
- Capture:
  - `in_valid && in_ready` loads `in_data` into an internal shadow register and clears the lane counter to 0.
  - The state becomes `SEND`.
- Beat: in `SEND`, `out_data` is the shadow slice selected by the lane counter, and `out_lane` equals the lane counter.
  - `out_valid && out_ready` with lane < `LANES-1`: lane counter increments.
  - `out_valid && out_ready` with lane == `LANES-1`: this is the final beat. With no new vector captured, the state goes to `IDLE` and the lane counter goes to 0.
- Back-to-back transfer:
  - In `SEND`, `in_ready = (lane == LANES-1) && out_ready`. This path is combinational from `out_ready`.
  - If a capture coincides with the final beat, the new vector is loaded, the lane counter goes to 0, and the state stays in `SEND`. No bubble is inserted.
- `busy` is 1 in `SEND` and 0 in `IDLE`.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_lane` and `out_last` stay stable. The shadow register must not change.
- `in_valid` asserted while `in_ready` is 0 is ignored. Upstream must hold the vector until the handshake completes.
- `LANES == 1`: each vector produces exactly one beat, and `out_lane` is always 0.

## Timing
- Reset values: state `IDLE`, lane counter 0, shadow register 0, `out_valid` 0, `out_data` 0, `out_lane` 0, `busy` 0, `out_last` 0, `in_ready` 1.
- Reset asserted mid-vector discards the remaining lanes immediately. No partial beat follows.
- Latency: the first beat is valid in the cycle after the capture edge.
- Throughput: one lane per cycle when `out_ready` is held high. With back-to-back capture, a vector completes every `LANES` cycles.
- All state updates happen on the rising edge of `clk`. The only combinational input-to-output paths are `out_ready` to `in_ready` and the `out_data` mux.

## Configuration
- Macro `VEC_SERIALIZER_LAST_EN`:
  - When defined, the `out_last` port exists and equals `out_valid && (lane == LANES-1)`.
  - When undefined, the port is absent. No other behaviour changes.

## Structure
- Shared package `vec_serializer_pkg` holds:
  - the state typedef `ser_state_t` with values `SER_IDLE` and `SER_SEND`;
  - a `lane_w` function computing `LANE_W`.
- One sub-module, `lane_counter`: a `LANE_W`-bit counter with clear and increment, and a terminal flag at `LANES-1`.
- The shadow register and output mux stay in the top level.

## Test plan
For all scenarios, `DATA_W=16` and `LANES=4`.
1. Reset check: release `reset` → `in_ready=1`, `out_valid=0`, `busy=0`.
2. Single vector: `in_data=64'h4444_3333_2222_1111`, `out_ready=1` → beats `1111`, `2222`, `3333`, `4444` on lanes 0–3 in four consecutive cycles. `out_last=1` only on the `4444` beat. Then `IDLE`.
3. Backpressure: during scenario 2, hold `out_ready=0` for 3 cycles on lane 1 → `out_data=2222` and `out_lane=1` stay stable. Then the stream resumes with `3333`.
4. Back-to-back: present a second vector `64'hDDDD_CCCC_BBBB_AAAA` with `in_valid=1` throughout → `in_ready` pulses on the `4444` beat. `AAAA` follows `4444` in the very next cycle. Eight beats are delivered in eight cycles.
5. Reset mid-operation: assert `reset` after beat `2222` → `out_valid` drops immediately. After release, a new vector starts at lane 0.
6. Ignored input: drive `in_valid=1` with different data while on lane 1 → the current vector's beats are unchanged, and the new data is captured only at the final-beat handshake.
